// File: rtl/ctrl_seq.sv
// Six-state T-ring controller-sequencer: fixed fetch (T1..T3) plus opcode-decoded execute (T4..T6).
// Controls are combinational decodes of state/opcode/zero; clr forces RST asynchronously, HLT parks in HALT.
module ctrl_seq (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       zero,
  output logic       pc_oen,
  output logic       pc_inc,
  output logic       load_pc,
  output logic       mar_load,
  output logic       mem_oen,
  output logic       ir_load,
  output logic       ir_oen,
  output logic       acc_load,
  output logic       acc_oen,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_oen,
  output logic       out_load,
  output logic       halt,
  output logic [5:0] t_state
);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JZ  = 4'h4;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:   state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3:    state <= S_T4;
        S_T4:    state <= (opcode == OP_HLT) ? S_HALT : S_T5;
        S_T5:    state <= S_T6;
        S_T6:    state <= S_T1;
        S_HALT:  state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    pc_oen   = 1'b1;
    pc_inc   = 1'b0;
    load_pc  = 1'b0;
    mar_load = 1'b0;
    mem_oen  = 1'b1;
    ir_load  = 1'b0;
    ir_oen   = 1'b1;
    acc_load = 1'b0;
    acc_oen  = 1'b1;
    b_load   = 1'b0;
    alu_sub  = 1'b0;
    alu_oen  = 1'b1;
    out_load = 1'b0;
    halt     = 1'b0;
    t_state  = 6'b000000;

    case (state)
      S_T1: begin
        t_state  = 6'b000001;
        pc_oen   = 1'b0;
        mar_load = 1'b1;
      end
      S_T2: begin
        t_state = 6'b000010;
        pc_inc  = 1'b1;
      end
      S_T3: begin
        t_state = 6'b000100;
        mem_oen = 1'b0;
        ir_load = 1'b1;
      end
      S_T4: begin
        t_state = 6'b001000;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ir_oen   = 1'b0;
            mar_load = 1'b1;
          end
          OP_JMP: begin
            ir_oen  = 1'b0;
            load_pc = 1'b1;
          end
          OP_JZ: begin
            // Branch not taken leaves T4 idle; the PC already points past the JZ.
            ir_oen  = ~zero;
            load_pc = zero;
          end
          OP_OUT: begin
            acc_oen  = 1'b0;
            out_load = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        t_state = 6'b010000;
        case (opcode)
          OP_LDA: begin
            mem_oen  = 1'b0;
            acc_load = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            mem_oen = 1'b0;
            b_load  = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        t_state = 6'b100000;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          alu_oen  = 1'b0;
          acc_load = 1'b1;
          alu_sub  = (opcode == OP_SUB);
        end
      end
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: checks every T-state's control word against hand-built masks.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] opcode;
  logic       zero;
  logic       pc_oen, pc_inc, load_pc, mar_load, mem_oen, ir_load, ir_oen;
  logic       acc_load, acc_oen, b_load, alu_sub, alu_oen, out_load, halt;
  logic [5:0] t_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_seq dut (
    .clk(clk), .clr(clr), .opcode(opcode), .zero(zero),
    .pc_oen(pc_oen), .pc_inc(pc_inc), .load_pc(load_pc), .mar_load(mar_load),
    .mem_oen(mem_oen), .ir_load(ir_load), .ir_oen(ir_oen), .acc_load(acc_load),
    .acc_oen(acc_oen), .b_load(b_load), .alu_sub(alu_sub), .alu_oen(alu_oen),
    .out_load(out_load), .halt(halt), .t_state(t_state)
  );

  localparam logic [13:0] PC_OEN   = 14'd1 << 13;
  localparam logic [13:0] PC_INC   = 14'd1 << 12;
  localparam logic [13:0] LOAD_PC  = 14'd1 << 11;
  localparam logic [13:0] MAR_LOAD = 14'd1 << 10;
  localparam logic [13:0] MEM_OEN  = 14'd1 << 9;
  localparam logic [13:0] IR_LOAD  = 14'd1 << 8;
  localparam logic [13:0] IR_OEN   = 14'd1 << 7;
  localparam logic [13:0] ACC_LOAD = 14'd1 << 6;
  localparam logic [13:0] ACC_OEN  = 14'd1 << 5;
  localparam logic [13:0] B_LOAD   = 14'd1 << 4;
  localparam logic [13:0] ALU_SUB  = 14'd1 << 3;
  localparam logic [13:0] ALU_OEN  = 14'd1 << 2;
  localparam logic [13:0] OUT_LOAD = 14'd1 << 1;
  localparam logic [13:0] HALT     = 14'd1 << 0;
  // Inactive word: active-low strobes high, everything else low.
  localparam logic [13:0] IDLE = PC_OEN | MEM_OEN | IR_OEN | ACC_OEN | ALU_OEN;

  logic [13:0] ctl;
  assign ctl = {pc_oen, pc_inc, load_pc, mar_load, mem_oen, ir_load, ir_oen,
                acc_load, acc_oen, b_load, alu_sub, alu_oen, out_load, halt};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int ndrv;
    @(posedge clk);
    #1;
    ndrv = int'(!pc_oen) + int'(!mem_oen) + int'(!ir_oen) + int'(!acc_oen) + int'(!alu_oen);
    check("bus_excl", 32'(ndrv > 1), 32'd0);
    check("inc_and_load", 32'(pc_inc & load_pc), 32'd0);
  endtask

  task automatic check_word(input string tag, input logic [5:0] et, input logic [13:0] mask);
    check(tag, {12'd0, t_state, ctl}, {12'd0, et, IDLE ^ mask});
  endtask

  // Enters from RST or T6; leaves the sequencer in T6.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic z,
                           input logic [13:0] m4, input logic [13:0] m5, input logic [13:0] m6);
    logic [13:0] m [6];
    m[0] = PC_OEN | MAR_LOAD;
    m[1] = PC_INC;
    m[2] = MEM_OEN | IR_LOAD;
    m[3] = m4;
    m[4] = m5;
    m[5] = m6;
    opcode = op;
    zero   = z;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_word($sformatf("%s_T%0d", tag, i + 1), 6'(1 << i), m[i]);
    end
  endtask

  task automatic pulse_clr();
    #2 clr = 1'b1;
    #1 check_word("clr_rst", 6'b0, 14'd0);
    @(posedge clk);
    #1 check_word("clr_hold", 6'b0, 14'd0);
    clr = 1'b0;
  endtask

  initial begin
    clr    = 1'b1;
    opcode = 4'h0;
    zero   = 1'b0;
    #1 check_word("rst_async", 6'b0, 14'd0);
    tick(); check_word("rst_c1", 6'b0, 14'd0);
    tick(); check_word("rst_c2", 6'b0, 14'd0);
    clr = 1'b0;

    run_instr("LDA", 4'h0, 1'b0, IR_OEN | MAR_LOAD, MEM_OEN | ACC_LOAD, 14'd0);
    run_instr("ADD", 4'h1, 1'b0, IR_OEN | MAR_LOAD, MEM_OEN | B_LOAD, ALU_OEN | ACC_LOAD);
    run_instr("SUB", 4'h2, 1'b0, IR_OEN | MAR_LOAD, MEM_OEN | B_LOAD, ALU_OEN | ACC_LOAD | ALU_SUB);
    run_instr("JMP", 4'h3, 1'b0, IR_OEN | LOAD_PC, 14'd0, 14'd0);
    run_instr("JZ1", 4'h4, 1'b1, IR_OEN | LOAD_PC, 14'd0, 14'd0);
    run_instr("JZ0", 4'h4, 1'b0, 14'd0, 14'd0, 14'd0);
    run_instr("OUT", 4'hE, 1'b1, ACC_OEN | OUT_LOAD, 14'd0, 14'd0);
    run_instr("NOP5", 4'h5, 1'b1, 14'd0, 14'd0, 14'd0);
    run_instr("NOPD", 4'hD, 1'b0, 14'd0, 14'd0, 14'd0);

    // Every non-halting opcode, both zero values; exclusivity is checked in tick().
    for (int op = 0; op < 15; op++) begin
      for (int z = 0; z < 2; z++) begin
        opcode = 4'(op);
        zero   = z[0];
        for (int i = 0; i < 6; i++) begin
          tick();
          check($sformatf("sweep_%0h_%0d_T%0d", op, z, i + 1), {26'd0, t_state}, 32'(1 << i));
        end
      end
    end

    // HLT: fetch, idle T4, then parked in HALT.
    opcode = 4'hF;
    zero   = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_word("HLT_T3", 6'b000100, MEM_OEN | IR_LOAD);
    tick(); check_word("HLT_T4", 6'b001000, 14'd0);
    for (int i = 0; i < 11; i++) begin
      tick();
      check_word($sformatf("HALT_c%0d", i), 6'b0, HALT);
    end
    pulse_clr();
    tick(); check_word("HALT_exit_T1", 6'b000001, PC_OEN | MAR_LOAD);
    opcode = 4'h0;
    for (int i = 0; i < 5; i++) tick();
    check_word("after_halt_T6", 6'b100000, 14'd0);

    // Mid-instruction reset during T5 of ADD.
    opcode = 4'h1;
    zero   = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_word("ADD_mid_T5", 6'b010000, MEM_OEN | B_LOAD);
    pulse_clr();
    run_instr("ADD_restart", 4'h1, 1'b0, IR_OEN | MAR_LOAD, MEM_OEN | B_LOAD, ALU_OEN | ACC_LOAD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Controller-sequencer for the 4-bit microprocessor: the block that drives the program counter's `pc_oen`, `pc_inc` and `load_pc` controls, together with the control strobes for the MAR, memory, IR, accumulator, B register, ALU and output register. A six-state T-ring runs one fixed-length fetch/execute cycle per instruction. It decodes the 4-bit opcode held in the IR and the accumulator zero flag, and sits between the IR and every bus-attached register.

## Interface
Parameters: none (opcode map and T-length are fixed).

- clk  in  1  system clock, rising-edge active
- clr  in  1  reset, asynchronous, active-high
- opcode  in  4  IR upper nibble; meaningful from T4 onward
- zero  in  1  accumulator == 0 flag; sampled during T4
- pc_oen  out  1  PC drives bus, active-low
- pc_inc  out  1  PC increment, active-high
- load_pc  out  1  PC loads from bus, active-high
- mar_load  out  1  MAR loads from bus
- mem_oen  out  1  memory drives bus, active-low
- ir_load  out  1  IR loads from bus
- ir_oen  out  1  IR operand nibble drives bus, active-low
- acc_load  out  1  accumulator loads from bus
- acc_oen  out  1  accumulator drives bus, active-low
- b_load  out  1  B register loads from bus
- alu_sub  out  1  ALU subtract select (0 = add)
- alu_oen  out  1  ALU result drives bus, active-low
- out_load  out  1  output register loads from bus
- halt  out  1  sequencer halted
- t_state  out  6  one-hot T1..T6 (bit0 = T1); all zero in RST/HALT

## Operation
- States: RST, T1..T6, HALT. RST -> T1 on the first clock edge after `clr` is released. Ti -> Ti+1, and T6 -> T1. HALT holds until `clr`.
- Inactive levels: active-low outputs 1, active-high outputs 0. In RST and HALT, all control outputs are inactive (`halt`=1 in HALT only).
- Fetch (same for every opcode):
  - T1: `pc_oen`=0, `mar_load`=1.
  - T2: `pc_inc`=1.
  - T3: `mem_oen`=0, `ir_load`=1.
- Execute, decoded from `opcode`:
  - LDA 0x0: T4 `ir_oen`=0, `mar_load`=1. T5 `mem_oen`=0, `acc_load`=1. T6 idle.
  - ADD 0x1: T4 as LDA. T5 `mem_oen`=0, `b_load`=1. T6 `alu_oen`=0, `acc_load`=1.
  - SUB 0x2: as ADD, with `alu_sub`=1 in T6 only.
  - JMP 0x3: T4 `ir_oen`=0, `load_pc`=1. T5/T6 idle.
  - JZ 0x4: T4 `ir_oen`=0 and `load_pc`=1 only if `zero`=1; otherwise idle. T5/T6 idle.
  - OUT 0xE: T4 `acc_oen`=0, `out_load`=1. T5/T6 idle.
  - HLT 0xF: T4 all controls idle; the next state is HALT instead of T5.
  - 0x5..0xD: NOP; T4..T6 idle.
- At most one bus driver (`*_oen`=0) is asserted in any state. Conflicts are a design error, and the bench checks for them.
- `pc_inc` and `load_pc` are never asserted in the same state.

## Timing
- Control outputs are combinational decodes of the state register, `opcode` and `zero`. They are stable within a cycle once their inputs settle.
- The transfer commits at the rising edge that ends the state: the PC increments at the end of T2, and the IR captures at the end of T3.
- `opcode` must be stable from the end of T3 through T6. `zero` must be stable during T4.
- Instruction latency: 6 cycles for every opcode except HLT, which reaches HALT 4 cycles after entering T1.
- `clr` asserted in any state: the state goes to RST immediately (asynchronously), and all outputs go inactive in the same cycle. There is no partial completion of the interrupted instruction.
- `clr` released: the first clock edge enters T1, so `pc_oen`=0 in the first full cycle after release.

## Test plan
- Reset/fetch: hold `clr`=1 for 2 cycles, then release with `opcode`=0x0. Required: all outputs inactive while in reset. Then `t_state` = 000001, 000010, 000100 on successive cycles, with `pc_oen`=0/`mar_load`=1, then `pc_inc`=1, then `mem_oen`=0/`ir_load`=1.
- ADD vs SUB: `opcode`=0x1 for one instruction, then 0x2. Required: in T5 `mem_oen`=0 and `b_load`=1; in T6 `alu_oen`=0 and `acc_load`=1, with `alu_sub`=0 for ADD and 1 for SUB.
- JZ both ways: `opcode`=0x4 with `zero`=1, then with `zero`=0. Required: T4 `load_pc`=1 and `ir_oen`=0 in the first case. In the second case, T4 is idle and the next T1 follows after T6.
- HLT: `opcode`=0xF. Required: T4 idle, then `halt`=1 and `t_state`=000000 held for 10+ cycles. A subsequent `clr` pulse returns the sequencer to RST, then T1.
- Mid-instruction reset: assert `clr` asynchronously between edges during T5 of ADD. Required: `mem_oen` and `b_load` go inactive before the next edge. After release, the sequence restarts at T1.
- Bus exclusivity: run all 16 opcodes, each with `zero`=0 and `zero`=1. Required: never more than one `*_oen` low, and never `pc_inc` together with `load_pc`.
